// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_AW    = 3;
  localparam int AGE_W     = 2;
  localparam int ISSUE_AGE = 3;

  // Operand source select driven to the register bank read-port muxes
  typedef enum logic [1:0] {
    FWD_BANK  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_t;

  // Producer position as seen from the instruction sitting in ID
  localparam logic [AGE_W-1:0] AGE_EX  = 2'd3;
  localparam logic [AGE_W-1:0] AGE_MEM = 2'd2;
  localparam logic [AGE_W-1:0] AGE_WB  = 2'd1;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand decode of producer age/load flag into a forward select and a load-use hazard bit.
// Latency: purely combinational.
// Backpressure: none; the hazard bit feeds the parent's stall.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic             uses,
  input  logic [AGE_W-1:0] age,
  input  logic             ld,
  output fwd_sel_t         fwd_sel,
  output logic             hazard
);

  // A load still in EX cannot forward yet: flag the hazard and leave the bank selected
  always_comb begin
    fwd_sel = FWD_BANK;
    hazard  = 1'b0;
    if (uses) begin
      case (age)
        AGE_EX: begin
          if (ld) hazard  = 1'b1;
          else    fwd_sel = FWD_EXMEM;
        end
        AGE_MEM: fwd_sel = FWD_MEMWB;
        AGE_WB:  fwd_sel = FWD_WB;
        default: fwd_sel = FWD_BANK;
      endcase
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard control: per-register age scoreboard, load-use stall, operand forward selects.
// Latency: stall/fwd are combinational from current state; scoreboard updates on the next edge.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX for one cycle; optional SCOREBOARD_CHECK_EN adds sb_error.
module id_hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_writes,
  input  logic              id_is_load,
  input  logic              ex_flush,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_reg,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]       stall_count
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic              sb_error
`endif
);

  logic [AGE_W-1:0]    age [NUM_REGS];
  logic [NUM_REGS-1:0] ld;

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     haz_a;
  logic     haz_b;
  logic     issue;

  hazard_fwd_sel u_fwd_rs (
    .uses    (id_uses_rs),
    .age     (age[id_rs]),
    .ld      (ld[id_rs]),
    .fwd_sel (sel_a),
    .hazard  (haz_a)
  );

  hazard_fwd_sel u_fwd_rt (
    .uses    (id_uses_rt),
    .age     (age[id_rt]),
    .ld      (ld[id_rt]),
    .fwd_sel (sel_b),
    .hazard  (haz_b)
  );

  // Flush wins over stall; a stalled or flushed instruction never claims its destination
  always_comb begin
    stall        = id_valid & ~ex_flush & (haz_a | haz_b);
    issue        = id_valid & ~stall & ~ex_flush & id_writes;
    pc_write     = ~stall;
    if_id_write  = ~stall;
    id_ex_bubble = stall | ex_flush;
    fwd_a        = sel_a;
    fwd_b        = sel_b;
  end

  // Busy whenever a write is still in flight
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (age[r] != '0);
    end
  end

  // Ages count down one stage per cycle; a new issue to the same register replaces the older writer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        age[r] <= '0;
      end
      ld <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue && (id_dest == REG_AW'(r))) begin
          age[r] <= AGE_W'(ISSUE_AGE);
          ld[r]  <= id_is_load;
        end else if (age[r] != '0) begin
          age[r] <= age[r] - 1'b1;
        end
      end
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

`ifdef SCOREBOARD_CHECK_EN
  // Sticky flag: a bank write nobody issued, or a write landing on top of a load still in EX
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_error <= 1'b0;
    end else if ((wb_regwrite && (age[wb_reg] == '0)) ||
                 (issue && (age[id_dest] == AGE_EX) && ld[id_dest])) begin
      sb_error <= 1'b1;
    end
  end
`else
  // The write-back strobe only matters to the optional checker
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_reg};
`endif

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Hazard controller for the ID stage of the 16-bit, 8-register pipeline.
- Tracks in-flight register writes with a per-register age scoreboard.
- Generates load-use stalls (PC/IF-ID freeze plus an ID/EX bubble) and operand forwarding selects for the register bank's two read ports.
- Sits beside the register bank and sign extender; driven by decoded rs/rt/rd fields.

Parameters:
- NUM_REGS, 8, number of architectural registers.
- REG_AW, 3, register address width.
- AGE_W, 2, scoreboard age counter width.
- ISSUE_AGE, 3, age loaded on issue (producer reaches EX next cycle).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  3  source register A
- id_rt  in  3  source register B
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_dest  in  3  destination register (rt or rd, already muxed)
- id_writes  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- ex_flush  in  1  taken branch/jump squashes the ID instruction
- wb_regwrite  in  1  register bank write strobe (WB stage)
- wb_reg  in  3  register bank write address
- stall  out  1  load-use hazard detected
- pc_write  out  1  PC update enable (= !stall)
- if_id_write  out  1  IF/ID latch enable (= !stall)
- id_ex_bubble  out  1  insert NOP into ID/EX (stall | ex_flush)
- fwd_a  out  2  operand A source: 00 bank, 01 EX/MEM, 10 MEM/WB, 11 WB bypass
- fwd_b  out  2  operand B source, same encoding
- busy_mask  out  8  bit r set when age[r] != 0
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- State per register r: age[r] (AGE_W bits) and ld[r] (1 bit).
- Reset (async, reset_n=0): all age=0, ld=0, stall_count=0. Outputs: stall=0, pc_write=1, if_id_write=1, id_ex_bubble=0, fwd_a=fwd_b=00, busy_mask=0.
- Age meaning, as seen by the instruction in ID:
  - 3: producer in EX.
  - 2: producer in MEM.
  - 1: producer in WB.
  - 0: no pending write.
- Every rising edge, each nonzero age decrements by 1.
- issue = id_valid & !stall & !ex_flush & id_writes.
  - On issue: age[id_dest] <= ISSUE_AGE and ld[id_dest] <= id_is_load.
  - Issue overrides a simultaneous decrement, so the youngest writer wins.
- Hazard evaluation is combinational from current state, before the same-cycle issue updates it.
  - stall = id_valid & !ex_flush & ((id_uses_rs & age[id_rs]==3 & ld[id_rs]) | (id_uses_rt & age[id_rt]==3 & ld[id_rt])).
- Forward select per operand (rs→fwd_a, rt→fwd_b), 00 if the operand is unused:
  - age 3 and not load → 01
  - age 2 → 10
  - age 1 → 11
  - age 0 → 00
- A stalled instruction re-evaluates next cycle: age has become 2, so stall drops and fwd selects 10. Load-use costs exactly 1 bubble.
- ex_flush has priority: stall forced 0, no issue, id_ex_bubble=1. Ages of older in-flight producers keep decrementing.
- rs == rt == the same pending register: both selects are identical.
- id_dest equal to a source of the same instruction: the hazard check uses the old age; the new age applies from the next cycle.
- stall_count increments on each stall cycle and saturates at 16'hFFFF.
- wb_regwrite/wb_reg are used only by the optional checker.
- Reset mid-operation: the scoreboard clears immediately. Any in-flight pipeline contents are the owner's responsibility.

Optional Feature:
- Macro: SCOREBOARD_CHECK_EN.
- When defined, adds output sb_error (1 bit, sticky, cleared by reset).
  - sb_error sets when wb_regwrite=1 and age[wb_reg]==0, i.e. a write the scoreboard never saw.
  - It also sets when id_dest issues while age[id_dest]==3 & ld[id_dest], i.e. a write-after-load that would overlap in MEM.
- When undefined, the port and logic are absent, with no behavioural change.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_t encoding: FWD_BANK=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WB=2'b11.
  - REG_AW, NUM_REGS.
  - Age constants AGE_EX=3, AGE_MEM=2, AGE_WB=1.
- One natural sub-module, hazard_fwd_sel: the combinational per-operand age/ld → fwd_sel and hazard-bit decode, instantiated twice (rs, rt).

Test Plan:
- Reset: assert reset_n=0 mid-run with age[3]=2 → busy_mask=0, stall=0, pc_write=1, fwd=00 immediately, with no clock edge needed.
- ALU chain: issue ADD r2 (not load), next cycle a consumer reads rs=r2 → fwd_a=01, stall=0; the following cycle, consumer rt=r2 → fwd_b=10; the one after → 11; then 00.
- Load-use: issue LW r4, next cycle a consumer uses rs=r4 → stall=1, pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle; then stall=0, fwd_a=10; stall_count=1.
- Youngest writer: issue LW r5, then ADD r5 the next cycle → age[5]=3, ld[5]=0; a consumer of r5 gets fwd=01 with no stall.
- Flush: consumer of a just-loaded r1 with ex_flush=1 → stall=0, id_ex_bubble=1; no issue occurs even though id_writes=1 (its dest age stays at its pre-flush value, decrementing).
- Checker (SCOREBOARD_CHECK_EN): wb_regwrite=1, wb_reg=6 while age[6]=0 → sb_error=1 next edge, remaining set until reset_n=0.
